// File: rtl/mul_arb_pkg.sv
// Shared types and default sizing for the two-requester multiplier arbiter.
package mul_arb_pkg;
    localparam int MUL_W_DEF   = 64;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick with last-served pointer; grant is combinational, pointer registered.
// On a tie the requester not served last wins; pointer resets to requester 1.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       update,
    input  logic       owner,
    output logic [1:0] grant
);
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle multiplier between two requesters: accept, hold operands, wait for
// done (or abort on timeout), then pulse the owner's response. Latency L+3; one job in flight.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int W       = MUL_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           req0_ready,
    output logic           rsp0_valid,
    output logic [2*W-1:0] rsp0_result,
    output logic           rsp0_err,
    input  logic           req1_valid,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           req1_ready,
    output logic           rsp1_valid,
    output logic [2*W-1:0] rsp1_result,
    output logic           rsp1_err,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    output logic           mul_rst_n,
    input  logic [2*W-1:0] mul_result,
    input  logic           mul_ready_n
);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e     state_q, state_d;
    logic           owner_q, owner_d;
    logic [W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] res_q [2];
    logic [2*W-1:0] res_d [2];
    logic [1:0]     err_q, err_d;
    logic [1:0]     grant;
    logic           accept, done_hit, timeout_hit;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .update (state_q == ST_DONE),
        .owner  (owner_q),
        .grant  (grant)
    );

    assign accept      = (state_q == ST_IDLE) && !rst && (grant != 2'b00);
    // Counter 0 is the first RUN cycle, where a done left over from the previous job may linger.
    assign done_hit    = (state_q == ST_RUN) && (cnt_q != '0) && !mul_ready_n;
    assign timeout_hit = (state_q == ST_RUN) && !done_hit && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (done_hit || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && grant[0];
        req1_ready = accept && grant[1];
        mul_rst_n  = (state_q == ST_RUN);
        rsp0_valid = (state_q == ST_DONE) && !owner_q;
        rsp1_valid = (state_q == ST_DONE) && owner_q;
    end

    always_comb begin
        owner_d = owner_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        cnt_d   = (state_q == ST_RUN) ? cnt_q + CW'(1) : '0;
        res_d   = res_q;
        err_d   = err_q;
        if (accept) begin
            owner_d = grant[1];
            mul_a_d = grant[1] ? req1_a : req0_a;
            mul_b_d = grant[1] ? req1_b : req0_b;
        end
        if (done_hit) begin
            res_d[owner_q] = mul_result;
            err_d[owner_q] = 1'b0;
        end else if (timeout_hit) begin
            res_d[owner_q] = '0;
            err_d[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            cnt_q    <= '0;
            res_q[0] <= '0;
            res_q[1] <= '0;
            err_q    <= '0;
        end else begin
            owner_q  <= owner_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            cnt_q    <= cnt_d;
            res_q[0] <= res_d[0];
            res_q[1] <= res_d[1];
            err_q    <= err_d;
        end
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp0_result = res_q[0];
    assign rsp1_result = res_q[1];
    assign rsp0_err    = err_q[0];
    assign rsp1_err    = err_q[1];
endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter with a behavioural multiplier stub and an event-level reference model.
module tb_mul_arbiter;
    localparam int W  = 64;
    localparam int TO = 255;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic           req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [2*W-1:0] rsp0_result, rsp1_result, mul_result;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_rst_n, mul_ready_n;

    mul_arbiter #(.W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .mul_a(mul_a), .mul_b(mul_b), .mul_rst_n(mul_rst_n),
        .mul_result(mul_result), .mul_ready_n(mul_ready_n)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } op_t;
    typedef struct { int port; int t; logic [W-1:0] a; logic [W-1:0] b; bit tie; int dly; } acc_t;
    typedef struct { int port; int t; logic [2*W-1:0] res; logic err; } rsp_t;

    op_t  q0[$], q1[$], dmy;
    acc_t acc_q[$];
    rsp_t rsp_q[$];
    int   total = 0, bad = 0, cyc = 0;
    int   stub_dly = 1, stub_cnt = 0;
    bit   rand_dly = 0, took0 = 0, took1 = 0;
    int   both_rdy_viol = 0, rst_rdy_viol = 0, chg_viol = 0, low_run = 0, min_low = 1000;
    logic [2*W-1:0] p0r, p1r;
    logic           p0e, p1e;

    function automatic op_t mk_op(input logic [W-1:0] a, input logic [W-1:0] b);
        op_t o;
        o.a = a;
        o.b = b;
        return o;
    endfunction

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        return (2*W)'(a) * (2*W)'(b);
    endfunction

    // Done is seen on the first RUN cycle index >= max(dly,1); beyond TO-1 the job aborts.
    function automatic int exp_lat(input int dly);
        int l;
        l = (dly < 1) ? 1 : dly;
        return (l <= TO - 1) ? l + 3 : TO + 2;
    endfunction

    // Multiplier stub: done asserts once it has computed for stub_dly cycles.
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) stub_cnt <= (mul_rst_n === 1'b1) ? stub_cnt + 1 : 0;
    assign mul_ready_n = !(stub_cnt >= stub_dly);
    assign mul_result  = prod(mul_a, mul_b);

    always @(negedge clk) begin
        acc_t e;
        rsp_t r;
        if (req0_ready === 1'b1 && req1_ready === 1'b1) both_rdy_viol++;
        if (rst && (req0_ready === 1'b1 || req1_ready === 1'b1)) rst_rdy_viol++;
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
                    if (p == 0) took0 = 1; else took1 = 1;
                    if (rand_dly) stub_dly = $urandom_range(0, 6);
                    e.port = p; e.t = cyc + 1; e.dly = stub_dly;
                    e.a = (p == 0) ? req0_a : req1_a;
                    e.b = (p == 0) ? req0_b : req1_b;
                    e.tie = req0_valid && req1_valid;
                    acc_q.push_back(e);
                end
            end
            if (rsp0_valid === 1'b1) begin
                r.port = 0; r.t = cyc + 1; r.res = rsp0_result; r.err = rsp0_err;
                rsp_q.push_back(r);
            end
            if (rsp1_valid === 1'b1) begin
                r.port = 1; r.t = cyc + 1; r.res = rsp1_result; r.err = rsp1_err;
                rsp_q.push_back(r);
            end
            if (rsp0_valid !== 1'b1 && (rsp0_result !== p0r || rsp0_err !== p0e)) chg_viol++;
            if (rsp1_valid !== 1'b1 && (rsp1_result !== p1r || rsp1_err !== p1e)) chg_viol++;
        end
        p0r = rsp0_result; p0e = rsp0_err; p1r = rsp1_result; p1e = rsp1_err;
        if (mul_rst_n === 1'b1) begin
            if (low_run > 0 && low_run < min_low) min_low = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    // Requester driver: present the head of each queue, retire it after an accept.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (took0) begin
                if (q0.size() > 0) dmy = q0.pop_front();
                took0 = 0;
            end
            if (took1) begin
                if (q1.size() > 0) dmy = q1.pop_front();
                took1 = 0;
            end
            req0_valid = (q0.size() > 0);
            if (q0.size() > 0) begin req0_a = q0[0].a; req0_b = q0[0].b; end
            req1_valid = (q1.size() > 0);
            if (q1.size() > 0) begin req1_a = q1[0].a; req1_b = q1[0].b; end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        q0.delete(); q1.delete();
        took0 = 0; took1 = 0; rand_dly = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        acc_q.delete(); rsp_q.delete();
        min_low = 1000; low_run = 0;
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_q.size() >= n) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        q0.push_back(mk_op(64'd5, 64'd7));
        stub_dly = 3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", req0_ready); end
        total++; if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mul_rst_n} !== 5'b0) begin
            bad++; $display("FAIL rst_ctrl: got %b want 00000", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mul_rst_n}); end
        total++; if ((rsp0_result | rsp1_result) !== '0) begin bad++; $display("FAIL rst_res: got %0h want 0", rsp0_result | rsp1_result); end
        total++; if ((mul_a | mul_b) !== '0) begin bad++; $display("FAIL rst_mul_ab: got %0h want 0", mul_a | mul_b); end
        total++; if (acc_q.size() != 0) begin bad++; $display("FAIL rst_accept: got %0d want 0", acc_q.size()); end
        @(posedge clk); #1;
        rst = 1'b0; min_low = 1000; low_run = 0;
        wait_rsp(1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_after_rsp: got none want 1"); end
        if (ok) begin
            total++; if (rsp_q[0].res !== prod(64'd5, 64'd7)) begin bad++; $display("FAIL rst_after_res: got %0h want 23", rsp_q[0].res); end
            total++; if (rsp_q[0].t - acc_q[0].t != exp_lat(3)) begin bad++; $display("FAIL rst_after_lat: got %0d want %0d", rsp_q[0].t - acc_q[0].t, exp_lat(3)); end
        end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        stub_dly = 2;
        q0.push_back(mk_op(64'd1, 64'd1));
        wait_rsp(1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_rsp: got none want 1"); end
        if (ok) begin
            total++; if (rsp_q[0].port != 0) begin bad++; $display("FAIL single_port: got %0d want 0", rsp_q[0].port); end
            total++; if (rsp_q[0].t - acc_q[0].t != 5) begin bad++; $display("FAIL single_lat: got %0d want 5", rsp_q[0].t - acc_q[0].t); end
            total++; if (rsp_q[0].res !== 128'd1 || rsp_q[0].err !== 1'b0) begin
                bad++; $display("FAIL single_res: got %0h/%b want 1/0", rsp_q[0].res, rsp_q[0].err); end
        end
        repeat (4) @(negedge clk);
        total++; if (rsp_q.size() != 1 || rsp0_result !== 128'd1) begin
            bad++; $display("FAIL single_hold: got %0d pulses res %0h want 1 pulse res 1", rsp_q.size(), rsp0_result); end
        total++; if (rsp1_result !== '0 || rsp1_err !== 1'b0) begin bad++; $display("FAIL single_rsp1: got %0h want 0", rsp1_result); end
    endtask

    task automatic test_tie();
        bit ok;
        logic [W-1:0] ba, bb;
        ba = 64'h0000_ed91_f81f_da13;
        bb = 64'h0000_d91a_e301_dedd;
        do_reset();
        stub_dly = 3;
        @(posedge clk); #2;
        q0.push_back(mk_op(64'h10, 64'h100));
        q1.push_back(mk_op(ba, bb));
        wait_rsp(2, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL tie_rsp: got %0d want 2", rsp_q.size()); end
        if (ok) begin
            total++; if (acc_q[0].port != 0 || !acc_q[0].tie || acc_q[1].port != 1) begin
                bad++; $display("FAIL tie_order: got %0d,%0d tie=%0b want 0,1 tie=1", acc_q[0].port, acc_q[1].port, acc_q[0].tie); end
            total++; if (rsp_q[0].res !== 128'h1000) begin bad++; $display("FAIL tie_res0: got %0h want 1000", rsp_q[0].res); end
            total++; if (rsp_q[1].res !== prod(ba, bb)) begin bad++; $display("FAIL tie_res1: got %0h want %0h", rsp_q[1].res, prod(ba, bb)); end
            total++; if (acc_q[1].t - acc_q[0].t != exp_lat(3) + 1) begin
                bad++; $display("FAIL tie_spacing: got %0d want %0d", acc_q[1].t - acc_q[0].t, exp_lat(3) + 1); end
        end
        total++; if (rsp0_result !== 128'h1000) begin bad++; $display("FAIL tie_hold0: got %0h want 1000", rsp0_result); end
    endtask

    task automatic test_alternate();
        bit ok;
        do_reset();
        rand_dly = 1;
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk_op({$urandom, $urandom}, {$urandom, $urandom}));
            q1.push_back(mk_op({$urandom, $urandom}, {$urandom, $urandom}));
        end
        wait_rsp(6, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL alt_rsp: got %0d want 6", rsp_q.size()); end
        if (ok) begin
            for (int i = 0; i < 6; i++) begin
                total++; if (acc_q[i].port != i % 2 || rsp_q[i].port != i % 2) begin
                    bad++; $display("FAIL alt_grant%0d: got %0d/%0d want %0d", i, acc_q[i].port, rsp_q[i].port, i % 2); end
                total++; if (rsp_q[i].res !== prod(acc_q[i].a, acc_q[i].b) || rsp_q[i].t - acc_q[i].t != exp_lat(acc_q[i].dly)) begin
                    bad++; $display("FAIL alt_rsp%0d: got %0h lat %0d want %0h lat %0d", i, rsp_q[i].res,
                                    rsp_q[i].t - acc_q[i].t, prod(acc_q[i].a, acc_q[i].b), exp_lat(acc_q[i].dly)); end
            end
        end
        total++; if (min_low < 2) begin bad++; $display("FAIL alt_low_gap: got %0d want >=2", min_low); end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [W-1:0] a, b;
        do_reset();
        stub_dly = 2;
        q1.push_back(mk_op(64'd9, 64'd9));
        wait_rsp(1, 50, ok);
        stub_dly = 100000;
        q1.push_back(mk_op(64'd3, 64'd4));
        wait_rsp(2, 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_rsp: got none want 1"); end
        if (ok) begin
            total++; if (rsp_q[1].port != 1 || rsp_q[1].err !== 1'b1 || rsp_q[1].res !== '0) begin
                bad++; $display("FAIL to_abort: got port %0d err %b res %0h want 1/1/0", rsp_q[1].port, rsp_q[1].err, rsp_q[1].res); end
            total++; if (rsp_q[1].t - acc_q[1].t != exp_lat(stub_dly)) begin
                bad++; $display("FAIL to_lat: got %0d want %0d", rsp_q[1].t - acc_q[1].t, exp_lat(stub_dly)); end
        end
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        stub_dly = 4;
        q1.push_back(mk_op(a, b));
        wait_rsp(3, 60, ok);
        @(negedge clk);
        total++; if (!ok || rsp1_err !== 1'b0 || rsp1_result !== prod(a, b)) begin
            bad++; $display("FAIL to_recover: got err %b res %0h want 0 %0h", rsp1_err, rsp1_result, prod(a, b)); end
    endtask

    task automatic test_stale_done();
        bit ok;
        logic [W-1:0] a, b;
        do_reset();
        stub_dly = 0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        q0.push_back(mk_op(a, b));
        wait_rsp(1, 50, ok);
        total++; if (!ok || rsp_q[0].t - acc_q[0].t != 4) begin
            bad++; $display("FAIL stale_lat: got %0d want 4", ok ? rsp_q[0].t - acc_q[0].t : -1); end
        total++; if (!ok || rsp_q[0].res !== prod(a, b)) begin bad++; $display("FAIL stale_res: got %0h want %0h", rsp0_result, prod(a, b)); end
    endtask

    task automatic test_rst_mid_run();
        bit ok;
        do_reset();
        stub_dly = 100000;
        q1.push_back(mk_op(64'd11, 64'd13));
        for (int i = 0; i < 50 && acc_q.size() == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        total++; if (acc_q.size() != 1 || mul_rst_n !== 1'b1) begin
            bad++; $display("FAIL mid_in_run: got acc %0d mul_rst_n %b want 1 1", acc_q.size(), mul_rst_n); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (mul_rst_n !== 1'b0) begin bad++; $display("FAIL mid_mul_rst_n: got %b want 0", mul_rst_n); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (rsp_q.size() != 0) begin bad++; $display("FAIL mid_no_rsp: got %0d want 0", rsp_q.size()); end
        @(posedge clk); #2;
        stub_dly = 2;
        q0.push_back(mk_op(64'd2, 64'd3));
        q1.push_back(mk_op(64'd4, 64'd5));
        wait_rsp(1, 50, ok);
        total++; if (!ok || acc_q.size() < 2 || acc_q[1].port != 0 || !acc_q[1].tie || rsp_q[0].port != 0) begin
            bad++; $display("FAIL mid_tie: got acc %0d first rsp port %0d want req0", acc_q.size(), ok ? rsp_q[0].port : -1); end
        wait_rsp(2, 50, ok);
    endtask

    task automatic test_random();
        bit ok;
        int last, exp_p;
        op_t m0[$], m1[$], e;
        do_reset();
        rand_dly = 1;
        @(posedge clk); #2;
        for (int i = 0; i < 16; i++) begin
            e = mk_op({$urandom, $urandom}, {$urandom, $urandom});
            if ($urandom_range(0, 1) == 0) begin q0.push_back(e); m0.push_back(e); end
            else begin q1.push_back(e); m1.push_back(e); end
        end
        wait_rsp(16, 600, ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_rsp: got %0d want 16", rsp_q.size()); end
        last = 1;
        for (int i = 0; i < 16 && ok; i++) begin
            exp_p = acc_q[i].tie ? 1 - last : ((m0.size() > 0) ? 0 : 1);
            e = (acc_q[i].port == 0) ? m0.pop_front() : m1.pop_front();
            total++; if (acc_q[i].port != exp_p || acc_q[i].a !== e.a || acc_q[i].b !== e.b) begin
                bad++; $display("FAIL rnd_acc%0d: got port %0d a %0h want port %0d a %0h", i, acc_q[i].port, acc_q[i].a, exp_p, e.a); end
            total++; if (rsp_q[i].port != acc_q[i].port || rsp_q[i].res !== prod(e.a, e.b) || rsp_q[i].err !== 1'b0
                         || rsp_q[i].t - acc_q[i].t != exp_lat(acc_q[i].dly)) begin
                bad++; $display("FAIL rnd_rsp%0d: got %0h lat %0d want %0h lat %0d", i, rsp_q[i].res,
                                rsp_q[i].t - acc_q[i].t, prod(e.a, e.b), exp_lat(acc_q[i].dly)); end
            last = acc_q[i].port;
        end
        total++; if (min_low < 2) begin bad++; $display("FAIL rnd_low_gap: got %0d want >=2", min_low); end
    endtask

    task automatic test_invariants();
        total++; if (both_rdy_viol != 0) begin bad++; $display("FAIL inv_both_ready: got %0d want 0", both_rdy_viol); end
        total++; if (rst_rdy_viol != 0) begin bad++; $display("FAIL inv_rst_ready: got %0d want 0", rst_rdy_viol); end
        total++; if (chg_viol != 0) begin bad++; $display("FAIL inv_rsp_change: got %0d want 0", chg_viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_timeout();
        test_stale_done();
        test_rst_mid_run();
        test_random();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
